p4_router_queue_state_table: RTL and testbench

// - Per-queue state store for the P4 router shared packet buffer, run at word granularity.
// - Tracks, per queue: byte occupancy, word count, head word/page, tail word/page and an ordered page list.
// - Returns the buffer write address for each enqueued word and the read address for each dequeued word.
// - Returns freed pages to the page allocator, flags almost-full, rejects underflow.
// - Sits between the enqueue/dequeue engines and the page allocator; generalises the previous queue-state block.

---
 rtl/p4_router_pkg.sv | 42 ++++
 rtl/p4_router_page_list_ram.sv | 40 ++++
 rtl/p4_router_queue_state_table.sv | 200 ++++++++++++++++++++
 tb/tb_p4_router_queue_state_table.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/p4_router_pkg.sv
// Shared types and sizing for the P4 router queue-state table and its page-list RAM.
package p4_router_pkg;

    localparam int NUM_QUEUES      = 16;
    localparam int NUM_PAGES       = 1024;
    localparam int WORDS_PER_PAGE  = 64;
    localparam int PAGES_PER_QUEUE = 32;
    localparam int OCC_WIDTH       = 24;
    localparam int BYTE_WIDTH      = 8;

    localparam int QID_WIDTH  = $clog2(NUM_QUEUES);
    localparam int PAGE_WIDTH = $clog2(NUM_PAGES);
    localparam int WORD_WIDTH = $clog2(WORDS_PER_PAGE);
    localparam int LIST_WIDTH = $clog2(PAGES_PER_QUEUE);
    localparam int PTR_WIDTH  = LIST_WIDTH + 1;
    // A full list holds PAGES_PER_QUEUE*WORDS_PER_PAGE words, so one extra bit is needed.
    localparam int CNT_WIDTH  = LIST_WIDTH + WORD_WIDTH + 1;

    typedef struct packed {
        logic [OCC_WIDTH-1:0]  occ;
        logic [CNT_WIDTH-1:0]  words;
        logic [WORD_WIDTH-1:0] head_word;
        logic [WORD_WIDTH-1:0] tail_word;
        logic [PAGE_WIDTH-1:0] tail_page;
        logic [PTR_WIDTH-1:0]  wr_ptr;
        logic [PTR_WIDTH-1:0]  rd_ptr;
    } queue_state_t;

    function automatic logic [OCC_WIDTH-1:0] occ_add_sat(
        input logic [OCC_WIDTH-1:0]  occ,
        input logic [BYTE_WIDTH-1:0] bytes
    );
        logic [OCC_WIDTH:0] sum;
        sum = {1'b0, occ} + (OCC_WIDTH+1)'(bytes);
        if (sum[OCC_WIDTH]) begin
            return {OCC_WIDTH{1'b1}};
        end else begin
            return sum[OCC_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/p4_router_page_list_ram.sv
// Per-queue ordered page lists: 1 write / 1 read port, write-first, registered read data.
module p4_router_page_list_ram
    import p4_router_pkg::*;
#(
    parameter int DEPTH = NUM_QUEUES * PAGES_PER_QUEUE,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = PAGE_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rd_data_r;

    // Storage array; contents are meaningless until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register; a same-address write in the same cycle is forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {DW{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/p4_router_queue_state_table.sv
// Per-queue occupancy / pointer store for the shared packet buffer: enqueue write addresses,
// 2-cycle dequeue read addresses, page release, almost-full and underflow reporting.
module p4_router_queue_state_table
    import p4_router_pkg::*;
(
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [QID_WIDTH-1:0]  enq_qid,
    input  logic [BYTE_WIDTH-1:0] enq_bytes,
    input  logic [PAGE_WIDTH-1:0] enq_page,
    output logic                  enq_rsp_valid,
    output logic [PAGE_WIDTH-1:0] enq_rsp_page,
    output logic [WORD_WIDTH-1:0] enq_rsp_word,
    input  logic                  deq_valid,
    input  logic [QID_WIDTH-1:0]  deq_qid,
    input  logic [BYTE_WIDTH-1:0] deq_bytes,
    output logic                  deq_rsp_valid,
    output logic [PAGE_WIDTH-1:0] deq_rsp_page,
    output logic [WORD_WIDTH-1:0] deq_rsp_word,
    output logic                  free_valid,
    output logic [PAGE_WIDTH-1:0] free_page,
    input  logic [OCC_WIDTH-1:0]  cfg_almost_full,
    output logic [NUM_QUEUES-1:0] queue_empty,
    output logic [NUM_QUEUES-1:0] queue_almost_full,
    output logic                  err_underflow,
    output logic [QID_WIDTH-1:0]  err_qid
);

    logic [1:0]            rst_sync_r;
    logic                  rst_n_s;
    queue_state_t          state_r   [NUM_QUEUES];
    queue_state_t          state_n_s [NUM_QUEUES];
    queue_state_t          enq_cur_s, deq_cur_s, enq_upd_s, deq_upd_s;
    logic                  need_page_s, list_full_s, enq_fire_s;
    logic                  deq_ok_s, deq_last_s, deq_clamp_s, err_s;
    logic [PAGE_WIDTH-1:0] ram_rd_data_s;

    logic                  enq_rsp_valid_r, s1_valid_r, s1_last_r;
    logic [PAGE_WIDTH-1:0] enq_rsp_page_r;
    logic [WORD_WIDTH-1:0] enq_rsp_word_r, s1_word_r;
    logic                  deq_rsp_valid_r, free_valid_r, err_underflow_r;
    logic [PAGE_WIDTH-1:0] deq_rsp_page_r, free_page_r;
    logic [WORD_WIDTH-1:0] deq_rsp_word_r;
    logic [QID_WIDTH-1:0]  err_qid_r;
    logic [NUM_QUEUES-1:0] queue_empty_r, queue_almost_full_r;

    // Reset synchroniser: asserts with aresetn, releases on a clock edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    assign enq_cur_s   = state_r[enq_qid];
    assign deq_cur_s   = state_r[deq_qid];
    assign need_page_s = (enq_cur_s.tail_word == {WORD_WIDTH{1'b0}});
    assign list_full_s = ((enq_cur_s.wr_ptr - enq_cur_s.rd_ptr) == PTR_WIDTH'(PAGES_PER_QUEUE));
    assign enq_ready   = !(need_page_s && list_full_s);
    assign enq_fire_s  = enq_valid && enq_ready;
    // Acceptance looks only at the word count held at the start of the cycle.
    assign deq_ok_s    = deq_valid && (deq_cur_s.words != {CNT_WIDTH{1'b0}});
    assign deq_last_s  = (deq_cur_s.head_word == WORD_WIDTH'(WORDS_PER_PAGE - 1));
    assign err_s       = (deq_valid && !deq_ok_s) || deq_clamp_s;

    // Next-state for the enqueue and dequeue targets; a shared queue gets one merged update.
    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            state_n_s[q] = state_r[q];
        end
        enq_upd_s   = enq_cur_s;
        deq_upd_s   = deq_cur_s;
        deq_clamp_s = 1'b0;
        if (enq_fire_s) begin
            if (need_page_s) begin
                enq_upd_s.tail_page = enq_page;
                enq_upd_s.wr_ptr    = enq_cur_s.wr_ptr + PTR_WIDTH'(1);
            end else begin
                enq_upd_s.tail_page = enq_cur_s.tail_page;
            end
            enq_upd_s.tail_word = enq_cur_s.tail_word + WORD_WIDTH'(1);
            enq_upd_s.words     = enq_cur_s.words + CNT_WIDTH'(1);
            enq_upd_s.occ       = occ_add_sat(enq_cur_s.occ, enq_bytes);
            state_n_s[enq_qid]  = enq_upd_s;
        end else begin
            state_n_s[enq_qid] = enq_cur_s;
        end
        if (deq_ok_s) begin
            deq_upd_s           = (enq_fire_s && (enq_qid == deq_qid)) ? enq_upd_s : deq_cur_s;
            deq_upd_s.head_word = deq_upd_s.head_word + WORD_WIDTH'(1);
            deq_upd_s.words     = deq_upd_s.words - CNT_WIDTH'(1);
            if (deq_last_s) begin
                deq_upd_s.rd_ptr = deq_upd_s.rd_ptr + PTR_WIDTH'(1);
            end else begin
                deq_upd_s.rd_ptr = deq_upd_s.rd_ptr;
            end
            if (OCC_WIDTH'(deq_bytes) > deq_upd_s.occ) begin
                deq_upd_s.occ = {OCC_WIDTH{1'b0}};
                deq_clamp_s   = 1'b1;
            end else begin
                deq_upd_s.occ = deq_upd_s.occ - OCC_WIDTH'(deq_bytes);
            end
            state_n_s[deq_qid] = deq_upd_s;
        end else begin
            deq_upd_s = deq_cur_s;
        end
    end

    // Queue state register array.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                state_r[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                state_r[q] <= state_n_s[q];
            end
        end
    end

    p4_router_page_list_ram u_page_list (
        .clk     (clk),
        .rst_n   (rst_n_s),
        .wr_en   (enq_fire_s && need_page_s),
        .wr_addr ({enq_qid, enq_cur_s.wr_ptr[LIST_WIDTH-1:0]}),
        .wr_data (enq_page),
        .rd_en   (deq_ok_s),
        .rd_addr ({deq_qid, deq_cur_s.rd_ptr[LIST_WIDTH-1:0]}),
        .rd_data (ram_rd_data_s)
    );

    // Enqueue response, dequeue stage 1 and error pulse.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            enq_rsp_valid_r <= 1'b0;
            enq_rsp_page_r  <= {PAGE_WIDTH{1'b0}};
            enq_rsp_word_r  <= {WORD_WIDTH{1'b0}};
            s1_valid_r      <= 1'b0;
            s1_last_r       <= 1'b0;
            s1_word_r       <= {WORD_WIDTH{1'b0}};
            err_underflow_r <= 1'b0;
            err_qid_r       <= {QID_WIDTH{1'b0}};
        end else begin
            enq_rsp_valid_r <= enq_fire_s;
            if (enq_fire_s) begin
                enq_rsp_page_r <= need_page_s ? enq_page : enq_cur_s.tail_page;
                enq_rsp_word_r <= enq_cur_s.tail_word;
            end
            s1_valid_r      <= deq_ok_s;
            s1_last_r       <= deq_ok_s && deq_last_s;
            s1_word_r       <= deq_cur_s.head_word;
            err_underflow_r <= err_s;
            if (err_s) begin
                err_qid_r <= deq_qid;
            end
        end
    end

    // Dequeue stage 2 (read data from the RAM register) and status flags.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            deq_rsp_valid_r     <= 1'b0;
            deq_rsp_page_r      <= {PAGE_WIDTH{1'b0}};
            deq_rsp_word_r      <= {WORD_WIDTH{1'b0}};
            free_valid_r        <= 1'b0;
            free_page_r         <= {PAGE_WIDTH{1'b0}};
            queue_empty_r       <= {NUM_QUEUES{1'b1}};
            queue_almost_full_r <= {NUM_QUEUES{1'b0}};
        end else begin
            deq_rsp_valid_r <= s1_valid_r;
            deq_rsp_page_r  <= ram_rd_data_s;
            deq_rsp_word_r  <= s1_word_r;
            free_valid_r    <= s1_last_r;
            free_page_r     <= ram_rd_data_s;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                queue_empty_r[q]       <= (state_n_s[q].words == {CNT_WIDTH{1'b0}});
                queue_almost_full_r[q] <= (state_n_s[q].occ >= cfg_almost_full);
            end
        end
    end

    assign enq_rsp_valid     = enq_rsp_valid_r;
    assign enq_rsp_page      = enq_rsp_page_r;
    assign enq_rsp_word      = enq_rsp_word_r;
    assign deq_rsp_valid     = deq_rsp_valid_r;
    assign deq_rsp_page      = deq_rsp_page_r;
    assign deq_rsp_word      = deq_rsp_word_r;
    assign free_valid        = free_valid_r;
    assign free_page         = free_page_r;
    assign queue_empty       = queue_empty_r;
    assign queue_almost_full = queue_almost_full_r;
    assign err_underflow     = err_underflow_r;
    assign err_qid           = err_qid_r;

endmodule

// File: tb/tb_p4_router_queue_state_table.sv
// Directed + randomized bench for p4_router_queue_state_table against a per-queue FIFO-of-addresses model.
module tb_p4_router_queue_state_table;
    import p4_router_pkg::*;

    localparam int NQ = NUM_QUEUES;
    localparam int WPP = WORDS_PER_PAGE;
    localparam int PPQ = PAGES_PER_QUEUE;
    localparam longint OCC_MAX = (64'd1 << OCC_WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  aresetn;
    logic                  enq_valid, enq_ready;
    logic [QID_WIDTH-1:0]  enq_qid;
    logic [BYTE_WIDTH-1:0] enq_bytes;
    logic [PAGE_WIDTH-1:0] enq_page;
    logic                  enq_rsp_valid;
    logic [PAGE_WIDTH-1:0] enq_rsp_page;
    logic [WORD_WIDTH-1:0] enq_rsp_word;
    logic                  deq_valid;
    logic [QID_WIDTH-1:0]  deq_qid;
    logic [BYTE_WIDTH-1:0] deq_bytes;
    logic                  deq_rsp_valid;
    logic [PAGE_WIDTH-1:0] deq_rsp_page;
    logic [WORD_WIDTH-1:0] deq_rsp_word;
    logic                  free_valid;
    logic [PAGE_WIDTH-1:0] free_page;
    logic [OCC_WIDTH-1:0]  cfg_almost_full;
    logic [NQ-1:0]         queue_empty, queue_almost_full;
    logic                  err_underflow;
    logic [QID_WIDTH-1:0]  err_qid;

    always #5 clk = ~clk;

    p4_router_queue_state_table dut (
        .clk(clk), .aresetn(aresetn),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_qid(enq_qid),
        .enq_bytes(enq_bytes), .enq_page(enq_page),
        .enq_rsp_valid(enq_rsp_valid), .enq_rsp_page(enq_rsp_page), .enq_rsp_word(enq_rsp_word),
        .deq_valid(deq_valid), .deq_qid(deq_qid), .deq_bytes(deq_bytes),
        .deq_rsp_valid(deq_rsp_valid), .deq_rsp_page(deq_rsp_page), .deq_rsp_word(deq_rsp_word),
        .free_valid(free_valid), .free_page(free_page),
        .cfg_almost_full(cfg_almost_full),
        .queue_empty(queue_empty), .queue_almost_full(queue_almost_full),
        .err_underflow(err_underflow), .err_qid(err_qid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each queue is a FIFO of absolute word addresses (page*WPP + word).
    int     mq [NQ][$];
    int     m_words [NQ];
    longint m_occ [NQ];
    int     m_tail [NQ];
    int     m_tailp [NQ];
    int     m_pages [NQ];
    int     m_errq;
    logic   p_v, p_free;
    int     p_page, p_word;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            mq[q].delete();
            m_words[q] = 0; m_occ[q] = 0; m_tail[q] = 0; m_tailp[q] = 0; m_pages[q] = 0;
        end
        m_errq = 0; p_v = 1'b0; p_free = 1'b0; p_page = 0; p_word = 0;
    endtask

    // Drive one cycle, advance the model, then check every output after the edge.
    task automatic run_cycle(input logic ev, input int eq, input int eb, input int ep,
                             input logic dv, input int dq, input int db);
        logic rdy, d_ok, e_v, d_free, cerr;
        int e_page, e_word, d_page, d_word, addr;
        logic [NQ-1:0] x_empty, x_af;
        e_page = 0; e_word = 0; d_page = 0; d_word = 0; d_free = 1'b0; cerr = 1'b0;
        enq_valid = ev; enq_qid = QID_WIDTH'(eq); enq_bytes = BYTE_WIDTH'(eb); enq_page = PAGE_WIDTH'(ep);
        deq_valid = dv; deq_qid = QID_WIDTH'(dq); deq_bytes = BYTE_WIDTH'(db);
        #1;
        rdy = !(m_tail[eq] == 0 && m_pages[eq] == PPQ);
        check("enq_ready", enq_ready, rdy);
        d_ok = dv && (m_words[dq] > 0);
        if (dv && !d_ok) begin cerr = 1'b1; m_errq = dq; end
        e_v = ev && rdy;
        if (e_v) begin
            if (m_tail[eq] == 0) begin m_tailp[eq] = ep; m_pages[eq]++; end
            e_page = m_tailp[eq]; e_word = m_tail[eq];
            mq[eq].push_back(e_page * WPP + e_word);
            m_tail[eq] = (m_tail[eq] + 1) % WPP;
            m_words[eq]++;
            m_occ[eq] = (m_occ[eq] + eb > OCC_MAX) ? OCC_MAX : m_occ[eq] + eb;
        end
        if (d_ok) begin
            addr = mq[dq].pop_front();
            d_page = addr / WPP; d_word = addr % WPP; d_free = (d_word == WPP - 1);
            if (d_free) m_pages[dq]--;
            m_words[dq]--;
            if (db > m_occ[dq]) begin m_occ[dq] = 0; cerr = 1'b1; m_errq = dq; end
            else m_occ[dq] = m_occ[dq] - db;
        end
        @(posedge clk); #1;
        check("enq_rsp_valid", enq_rsp_valid, e_v);
        if (e_v) begin
            check("enq_rsp_page", enq_rsp_page, e_page);
            check("enq_rsp_word", enq_rsp_word, e_word);
        end
        check("deq_rsp_valid", deq_rsp_valid, p_v);
        if (p_v) begin
            check("deq_rsp_page", deq_rsp_page, p_page);
            check("deq_rsp_word", deq_rsp_word, p_word);
        end
        check("free_valid", free_valid, p_v && p_free);
        if (p_v && p_free) check("free_page", free_page, p_page);
        check("err_underflow", err_underflow, cerr);
        check("err_qid", err_qid, m_errq);
        for (int q = 0; q < NQ; q++) begin
            x_empty[q] = (m_words[q] == 0);
            x_af[q]    = (m_occ[q] >= longint'(cfg_almost_full));
        end
        check("queue_empty", queue_empty, x_empty);
        check("queue_almost_full", queue_almost_full, x_af);
        p_v = d_ok; p_free = d_free; p_page = d_page; p_word = d_word;
    endtask

    task automatic idle();
        run_cycle(1'b0, 0, 0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        int ev, eq, eb, dv, dq, db, next_page;
        aresetn = 1'b0; enq_valid = 1'b0; enq_qid = '0; enq_bytes = '0; enq_page = '0;
        deq_valid = 1'b0; deq_qid = '0; deq_bytes = '0; cfg_almost_full = 24'd1000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_queue_empty", queue_empty, {NQ{1'b1}});
        check("rst_almost_full", queue_almost_full, {NQ{1'b0}});
        check("rst_valids", {enq_rsp_valid, deq_rsp_valid, free_valid, err_underflow}, 4'b0000);
        check("rst_enq_ready", enq_ready, 1'b1);
        #2 aresetn = 1'b1;
        repeat (3) idle();

        // Q3: 65 words of 8 bytes across pages 5 and 9
        for (int i = 0; i < 65; i++) run_cycle(1'b1, 3, 8, (i < 64) ? 5 : 9, 1'b0, 0, 0);
        check("q3_last_enq_page", enq_rsp_page, 10'd9);
        check("q3_last_enq_word", enq_rsp_word, 6'd0);
        cfg_almost_full = 24'd520; idle();
        check("q3_occ_520_af", queue_almost_full[3], 1'b1);
        cfg_almost_full = 24'd521; idle();
        check("q3_occ_below_521", queue_almost_full[3], 1'b0);

        // Q3: drain page 5; the last word frees it
        for (int i = 0; i < 64; i++) run_cycle(1'b0, 0, 0, 0, 1'b1, 3, 8);
        idle();
        check("q3_free_valid", free_valid, 1'b1);
        check("q3_free_page", free_page, 10'd5);
        check("q3_last_deq_word", deq_rsp_word, 6'd63);
        check("q3_one_word_left", queue_empty[3], 1'b0);
        cfg_almost_full = 24'd8; idle();
        check("q3_occ_8", queue_almost_full[3], 1'b1);

        // Q7 empty: rejected dequeue
        cfg_almost_full = 24'd1000;
        run_cycle(1'b0, 0, 0, 0, 1'b1, 7, 4);
        check("q7_err_pulse", err_underflow, 1'b1);
        check("q7_err_qid", err_qid, 4'd7);
        check("q7_still_empty", queue_empty[7], 1'b1);
        idle();
        check("q7_err_one_cycle", err_underflow, 1'b0);

        // Q1: occ 100, then simultaneous enq 8B / deq 20B
        cfg_almost_full = 24'd88;
        run_cycle(1'b1, 1, 100, 40, 1'b0, 0, 0);
        run_cycle(1'b1, 1, 8, 41, 1'b1, 1, 20);
        check("q1_af_at_88", queue_almost_full[1], 1'b1);
        check("q1_words_kept", queue_empty[1], 1'b0);
        cfg_almost_full = 24'd89; idle();
        check("q1_not_af_at_89", queue_almost_full[1], 1'b0);

        // Q2: fill the page list completely
        cfg_almost_full = 24'hFFFFFF;
        for (int i = 0; i < PPQ * WPP; i++) run_cycle(1'b1, 2, 1, 300 + i / WPP, 1'b0, 0, 0);
        enq_valid = 1'b0; enq_qid = 4'd2; #1;
        check("q2_full_not_ready", enq_ready, 1'b0);
        enq_qid = 4'd4; #1;
        check("q4_ready", enq_ready, 1'b1);
        run_cycle(1'b1, 2, 1, 999, 1'b0, 0, 0);

        // Randomized traffic on queues 7..15
        cfg_almost_full = 24'd40;
        next_page = 400;
        for (int i = 0; i < 600; i++) begin
            ev = int'($urandom_range(0, 1)); eq = int'($urandom_range(8, 15));
            eb = int'($urandom_range(1, 16));
            dv = int'($urandom_range(0, 1)); dq = int'($urandom_range(7, 15));
            db = int'($urandom_range(0, 24));
            if (m_words[eq] >= 150) ev = 0;
            if (($urandom_range(0, 7) == 0) && (ev != 0)) begin dq = eq; dv = 1; end
            run_cycle(ev[0], eq, eb, next_page, dv[0], dq, db);
            next_page++;
        end
        repeat (2) idle();

        // Reset in the middle of a dequeue burst
        cfg_almost_full = 24'd1000;
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 5, 4, 50, 1'b0, 0, 0);
        run_cycle(1'b0, 0, 0, 0, 1'b1, 5, 4);
        run_cycle(1'b0, 0, 0, 0, 1'b1, 5, 4);
        deq_valid = 1'b1; deq_qid = 4'd5; #2;
        aresetn = 1'b0; #1;
        check("midrst_deq_valid", deq_rsp_valid, 1'b0);
        check("midrst_other_valids", {enq_rsp_valid, free_valid, err_underflow}, 3'b000);
        deq_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 aresetn = 1'b1;
        model_reset();
        repeat (4) idle();
        check("postrst_all_empty", queue_empty, {NQ{1'b1}});
        cfg_almost_full = 24'd1; idle();
        check("postrst_occ_zero", queue_almost_full, {NQ{1'b0}});
        run_cycle(1'b1, 5, 4, 77, 1'b0, 0, 0);
        check("postrst_tail_word0", enq_rsp_word, 6'd0);
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
